// File: rtl/ifetch_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_pkg
// Shared definitions for the instruction-fetch pair buffer:
//   IFETCH_ADDR_W / IFETCH_WORD_W : default word-address and word widths
//   state_e                       : fetch engine state (IDLE, RUN)
//   entry_t                       : one queued instruction word with its pc
//   pair_base()                   : even address of the pair holding an address
// ---------------------------------------------------------------------------
package ifetch_pkg;

  localparam int unsigned IFETCH_ADDR_W = 10;
  localparam int unsigned IFETCH_WORD_W = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Queued word plus the address it was fetched from (default widths).
  typedef struct packed {
    logic [IFETCH_ADDR_W-1:0] pc;
    logic [IFETCH_WORD_W-1:0] word;
  } entry_t;

  // Even-aligned address of the word pair containing addr.
  function automatic logic [IFETCH_ADDR_W-1:0] pair_base(input logic [IFETCH_ADDR_W-1:0] addr);
    return {addr[IFETCH_ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ---------------------------------------------------------------------------
// ifetch_fifo
// Synchronous word+pc FIFO with a 2-wide push and a 1-wide pop.
// The caller must never push more entries than o_free reports.
// Ports:
//   clk, rst_n                : clock, synchronous active-low reset
//   i_clr                     : drop all entries (wins over push/pop)
//   i_push_n                  : number of entries pushed this cycle (0/1/2)
//   i_push_word0/pc0          : first pushed entry (older)
//   i_push_word1/pc1          : second pushed entry (only when i_push_n == 2)
//   i_pop                     : remove the head (ignored when empty)
//   o_valid, o_word, o_pc     : head entry
//   o_free                    : number of free slots, from current occupancy
//   i_snoop_addr, o_snoop_hit : tag compare against all valid entries
//                               (only with IFETCH_SNOOP_EN defined)
// ---------------------------------------------------------------------------
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W = IFETCH_ADDR_W,
  parameter int unsigned WORD_W = IFETCH_WORD_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic [1:0]        i_push_n,
  input  logic [WORD_W-1:0] i_push_word0,
  input  logic [ADDR_W-1:0] i_push_pc0,
  input  logic [WORD_W-1:0] i_push_word1,
  input  logic [ADDR_W-1:0] i_push_pc1,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_word,
  output logic [ADDR_W-1:0] o_pc,
  output logic [CNT_W-1:0]  o_free
`ifdef IFETCH_SNOOP_EN
  ,
  input  logic [ADDR_W-1:0] i_snoop_addr,
  output logic              o_snoop_hit
`endif
);

  logic [WORD_W-1:0] r_word [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [PTR_W-1:0]  r_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_pop;
  logic [PTR_W-1:0]  w_wr1;

  assign w_pop = i_pop && (r_cnt != '0);
  assign w_wr1 = r_wr + PTR_W'(1);

  // Head and occupancy views; storage is reset so the head reads 0 out of reset.
  assign o_valid = (r_cnt != '0);
  assign o_word  = r_word[r_rd];
  assign o_pc    = r_pc[r_rd];
  assign o_free  = CNT_W'(DEPTH) - r_cnt;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_word[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (i_clr) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push_n != 2'd0) begin
        r_word[r_wr] <= i_push_word0;
        r_pc[r_wr]   <= i_push_pc0;
      end
      if (i_push_n == 2'd2) begin
        r_word[w_wr1] <= i_push_word1;
        r_pc[w_wr1]   <= i_push_pc1;
      end
      r_wr  <= r_wr + PTR_W'(i_push_n);
      r_rd  <= r_rd + PTR_W'(w_pop);
      r_cnt <= r_cnt + CNT_W'(i_push_n) - CNT_W'(w_pop);
    end
  end

`ifdef IFETCH_SNOOP_EN
  // Compare the snoop address against every occupied slot, oldest first.
  always_comb begin
    o_snoop_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_cnt) && (r_pc[r_rd + PTR_W'(i)] == i_snoop_addr)) begin
        o_snoop_hit = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ifetch_pair_buffer.sv
// ---------------------------------------------------------------------------
// ifetch_pair_buffer
// Instruction-fetch front end: drives the word-pair RAM port, unpacks each
// 20-bit pair read into single words, queues them toward decode and lets
// execute-stage stores take the RAM port with priority over fetch.
// Optional feature macro: IFETCH_SNOOP_EN -- an accepted store that hits a
// queued word (or the pair at the fetch pc) flushes the queue and refetches
// from the oldest discarded pc.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   start, start_addr           : begin fetching at start_addr
//   redirect, redirect_addr     : flush and refetch at branch target
//   st_valid/st_addr/st_data    : store request, st_ready = accepted
//   mem_addr/mem_we/mem_wdata   : RAM port (combinational)
//   mem_rdata                   : RAM pair read {odd, even}
//   ins_valid/ins_word/ins_pc   : queue head toward decode
//   ins_ready                   : decode consumes the head
// ---------------------------------------------------------------------------
module ifetch_pair_buffer
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W = IFETCH_ADDR_W,
  parameter int unsigned WORD_W = IFETCH_WORD_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_addr,
  input  logic                st_valid,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [WORD_W-1:0]   st_data,
  output logic                st_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [2*WORD_W-1:0] mem_wdata,
  input  logic [2*WORD_W-1:0] mem_rdata,
  output logic                ins_valid,
  output logic [WORD_W-1:0]   ins_word,
  output logic [ADDR_W-1:0]   ins_pc,
  input  logic                ins_ready
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;

  logic              w_store;
  logic              w_load;
  logic              w_snoop;
  logic              w_clr;
  logic              w_fetch;
  logic              w_pop;
  logic [CNT_W-1:0]  w_need;
  logic [CNT_W-1:0]  w_free;
  logic [1:0]        w_push_n;
  logic [WORD_W-1:0] w_even;
  logic [WORD_W-1:0] w_odd;
  logic [WORD_W-1:0] w_push_word0;
  logic [ADDR_W-1:0] w_push_pc1;

  // Store/fetch port mux; stores win and are only blocked by reset.
  assign w_store   = st_valid && rst_n;
  assign st_ready  = w_store;
  assign mem_we    = w_store;
  assign mem_addr  = w_store ? st_addr : r_fetch_pc;
  assign mem_wdata = {st_data, WORD_W'(0)};

  // Pair unpack: an odd pc only needs the upper word of its pair.
  assign w_even       = mem_rdata[WORD_W-1:0];
  assign w_odd        = mem_rdata[2*WORD_W-1:WORD_W];
  assign w_need       = r_fetch_pc[0] ? CNT_W'(1) : CNT_W'(2);
  assign w_push_word0 = r_fetch_pc[0] ? w_odd : w_even;
  assign w_push_pc1   = r_fetch_pc + ADDR_W'(1);

`ifdef IFETCH_SNOOP_EN
  logic w_snoop_hit;
  // A store into a queued word, or into the pair about to be fetched, makes the queue stale.
  assign w_snoop = w_store &&
                   (w_snoop_hit ||
                    ((r_state == ST_RUN) && (st_addr[ADDR_W-1:1] == r_fetch_pc[ADDR_W-1:1])));
`else
  assign w_snoop = 1'b0;
`endif

  assign w_load  = start || redirect;
  assign w_clr   = w_load || w_snoop;
  // Free count is from current occupancy; a same-cycle pop does not make room.
  assign w_fetch = (r_state == ST_RUN) && !w_store && !w_clr && (w_free >= w_need);
  assign w_push_n = w_fetch ? 2'(w_need) : 2'd0;
  assign w_pop   = ins_valid && ins_ready && !w_clr;

  ifetch_fifo #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_clr),
    .i_push_n     (w_push_n),
    .i_push_word0 (w_push_word0),
    .i_push_pc0   (r_fetch_pc),
    .i_push_word1 (w_odd),
    .i_push_pc1   (w_push_pc1),
    .i_pop        (w_pop),
    .o_valid      (ins_valid),
    .o_word       (ins_word),
    .o_pc         (ins_pc),
    .o_free       (w_free)
`ifdef IFETCH_SNOOP_EN
    ,
    .i_snoop_addr (st_addr),
    .o_snoop_hit  (w_snoop_hit)
`endif
  );

  // Fetch engine: state and fetch pc. Redirect beats start beats snoop beats fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= '0;
    end else begin
      if (w_load) begin
        r_state <= ST_RUN;
      end
      if (redirect) begin
        r_fetch_pc <= redirect_addr;
      end else if (start) begin
        r_fetch_pc <= start_addr;
      end else if (w_snoop) begin
        // Resume at the oldest discarded word; with nothing queued that is the fetch pc itself.
        r_fetch_pc <= ins_valid ? ins_pc : r_fetch_pc;
      end else if (w_fetch) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(w_need);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_pair_buffer.sv
// ---------------------------------------------------------------------------
// tb_ifetch_pair_buffer
// Directed bench for ifetch_pair_buffer with a behavioural word-pair RAM.
// Expected words come from a bench-side golden image updated only by the
// stores this bench issues. Expectations for the store-snoop step follow
// IFETCH_SNOOP_EN.
// ---------------------------------------------------------------------------
module tb_ifetch_pair_buffer;

  localparam int unsigned AW = 10;
  localparam int unsigned WW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [WW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [2*WW-1:0] mem_wdata;
  logic [2*WW-1:0] mem_rdata;
  logic          ins_valid;
  logic [WW-1:0] ins_word;
  logic [AW-1:0] ins_pc;
  logic          ins_ready;

  int n_pass = 0;
  int n_chk  = 0;

  logic [WW-1:0] ram    [1024];
  logic [WW-1:0] golden [1024];
  logic [AW-1:0] exp_pc;

  always #5 clk = ~clk;

  ifetch_pair_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_addr    (start_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_ready      (st_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .ins_valid     (ins_valid),
    .ins_word      (ins_word),
    .ins_pc        (ins_pc),
    .ins_ready     (ins_ready)
  );

  function automatic logic [WW-1:0] init_word(input int i);
    if (i == 0) return 10'h00A;
    if (i == 1) return 10'h240;
    if (i == 2) return 10'h14B;
    return 10'(i * 37 + 5);
  endfunction

  // Word-pair RAM: asynchronous pair read, upper write-data half written.
  assign mem_rdata = {ram[{mem_addr[AW-1:1], 1'b1}], ram[{mem_addr[AW-1:1], 1'b0}]};

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata[2*WW-1:WW];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Consume n words at the head (ins_ready must be 1), checking pc order and content.
  task automatic stream(input string tag, input int n);
    int got = 0;
    int budget = 0;
    while (got < n && budget < 200) begin
      if (ins_valid) begin
        chk({tag, "_pc"}, 32'(ins_pc), 32'(exp_pc));
        chk({tag, "_word"}, 32'(ins_word), 32'(golden[exp_pc]));
        exp_pc = exp_pc + AW'(1);
        got++;
      end
      @(negedge clk);
      budget++;
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    start_addr = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; redirect = 1'b0; redirect_addr = '0;
    st_valid = 1'b1; st_addr = 10'd5; st_data = 10'h111; ins_ready = 1'b0;
    for (int i = 0; i < 1024; i++) golden[i] = init_word(i);

    // Reset values; a store request is refused while in reset.
    repeat (3) @(negedge clk);
    chk("rst_ins_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins_word", 32'(ins_word), 32'd0);
    chk("rst_ins_pc", 32'(ins_pc), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd0);
    st_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE: no fetching.
    repeat (3) @(negedge clk);
    chk("idle_valid", 32'(ins_valid), 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);

    // Start at 0: first word two cycles after the pulse.
    ins_ready = 1'b1;
    pulse_start(10'd0);
    chk("s0_lat1_valid", 32'(ins_valid), 32'd0);
    chk("s0_lat1_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    chk("s0_lat2_valid", 32'(ins_valid), 32'd1);
    chk("s0_pc0", 32'(ins_pc), 32'd0);
    chk("s0_word0", 32'(ins_word), 32'h00A);
    @(negedge clk);
    exp_pc = 10'd1;
    stream("s0", 5);

    // Start at odd address 1: single odd push first.
    pulse_start(10'd1);
    chk("s1_flushed", 32'(ins_valid), 32'd0);
    @(negedge clk);
    chk("s1_valid", 32'(ins_valid), 32'd1);
    chk("s1_pc", 32'(ins_pc), 32'd1);
    chk("s1_word", 32'(ins_word), 32'h240);
    @(negedge clk);
    exp_pc = 10'd2;
    stream("s1", 3);

    // Backpressure: exactly 4 words buffered, fetch halts at pc 4, then drains in order.
    ins_ready = 1'b0;
    pulse_start(10'd0);
    repeat (5) @(negedge clk);
    chk("bp_valid", 32'(ins_valid), 32'd1);
    chk("bp_head_pc", 32'(ins_pc), 32'd0);
    chk("bp_fetch_halt_pc", 32'(mem_addr), 32'd4);
    ins_ready = 1'b1;
    exp_pc = 10'd0;
    stream("bp", 7);

    // Store during streaming: port taken for one cycle, fetch pc held.
    pulse_start(10'd0);
    exp_pc = 10'd0;
    stream("st_pre", 4);
    chk("st_head_pc", 32'(ins_pc), 32'd4);
    exp_pc = 10'd5;
    st_valid = 1'b1; st_addr = 10'd12; st_data = 10'h007;
    #1;
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_addr", 32'(mem_addr), 32'd12);
    chk("st_ready", 32'(st_ready), 32'd1);
    chk("st_wdata", 32'(mem_wdata), 32'h01C00);
    golden[12] = 10'h007;
    @(negedge clk);
    st_valid = 1'b0;
    #1;
    chk("st_fetch_pc_held", 32'(mem_addr), 32'd6);
    chk("st_we_off", 32'(mem_we), 32'd0);
    stream("st_post", 10);

    // Redirect with a pop in the same cycle, plus a store that must still land.
    chk("rd_nonempty", 32'(ins_valid), 32'd1);
    redirect_addr = 10'd50; redirect = 1'b1;
    st_valid = 1'b1; st_addr = 10'd60; st_data = 10'h155;
    golden[60] = 10'h155;
    @(negedge clk);
    redirect = 1'b0; st_valid = 1'b0;
    chk("rd_flushed", 32'(ins_valid), 32'd0);
    @(negedge clk);
    chk("rd_valid", 32'(ins_valid), 32'd1);
    chk("rd_pc", 32'(ins_pc), 32'd50);
    chk("rd_word", 32'(ins_word), 32'(golden[50]));
    @(negedge clk);
    exp_pc = 10'd51;
    stream("rd", 12);

    // Address wrap: 1022, 1023, 0, 1, 2.
    pulse_start(10'd1022);
    chk("wr_flushed", 32'(ins_valid), 32'd0);
    @(negedge clk);
    chk("wr_pc", 32'(ins_pc), 32'd1022);
    chk("wr_word", 32'(ins_word), 32'(golden[1022]));
    @(negedge clk);
    exp_pc = 10'd1023;
    stream("wr", 4);

    // Store into a buffered word.
    ins_ready = 1'b0;
    pulse_start(10'd0);
    repeat (5) @(negedge clk);
    chk("sn_buffered_pc", 32'(ins_pc), 32'd0);
    chk("sn_halt_pc", 32'(mem_addr), 32'd4);
    st_valid = 1'b1; st_addr = 10'd2; st_data = 10'h3FF;
    @(negedge clk);
    st_valid = 1'b0;
`ifdef IFETCH_SNOOP_EN
    golden[2] = 10'h3FF;
    chk("sn_flush", 32'(ins_valid), 32'd0);
    chk("sn_refetch_pc", 32'(mem_addr), 32'd0);
    ins_ready = 1'b1;
    exp_pc = 10'd0;
    stream("sn", 6);
`else
    chk("sn_no_flush", 32'(ins_valid), 32'd1);
    chk("sn_head_pc", 32'(ins_pc), 32'd0);
    ins_ready = 1'b1;
    exp_pc = 10'd0;
    stream("sn_stale", 4);
    golden[2] = 10'h3FF;
    stream("sn_after", 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ifetch_pair_buffer.md
# ifetch_pair_buffer

Instruction-fetch front end for the 10-bit processor. Sits directly upstream of the word-pair RAM: drives its address/write port and consumes its 20-bit asynchronous pair read (`{odd word, even word}` of the aligned pair containing the address). Unpacks each pair into single 10-bit words, queues them in a small FIFO toward decode with valid/ready, and multiplexes execute-stage stores onto the same RAM port with priority over fetch.

## Interface
- `ADDR_W`, 10, word address width; RAM depth is 2^ADDR_W words
- `WORD_W`, 10, instruction/data word width
- `DEPTH`, 4, FIFO depth in words; power of 2, ≥ 2

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle pulse: begin fetching at `start_addr`
- `start_addr`  in  ADDR_W  first fetch address
- `redirect`  in  1  branch taken: flush FIFO, refetch from `redirect_addr`
- `redirect_addr`  in  ADDR_W  branch target
- `st_valid`  in  1  store request from execute
- `st_addr`  in  ADDR_W  store address
- `st_data`  in  WORD_W  store data
- `st_ready`  out  1  store accepted this cycle
- `mem_addr`  out  ADDR_W  RAM address
- `mem_we`  out  1  RAM write enable
- `mem_wdata`  out  2*WORD_W  RAM write data, `{st_data, WORD_W'b0}`; the RAM writes bits [19:10]
- `mem_rdata`  in  2*WORD_W  RAM pair read, combinational on `mem_addr`
- `ins_valid`  out  1  head word valid
- `ins_word`  out  WORD_W  head word
- `ins_pc`  out  ADDR_W  address of head word
- `ins_ready`  in  1  decode consumes head

## Operation
- States: IDLE (reset; no fetch) and RUN. IDLE→RUN on `start` or `redirect`. No transition out of RUN except reset.
- Port mux (combinational): `st_valid`=1 → `mem_addr=st_addr`, `mem_we=1`, `st_ready=1`. Otherwise `mem_addr=fetch_pc`, `mem_we=0`. Stores are accepted in both states; `st_ready` is 0 only while `rst_n`=0.
- Fetch cycle: RUN, no store, no redirect, and free slots ≥ need, where need=2 if `fetch_pc` is even and 1 if odd. Pushes the even word `mem_rdata[9:0]` (even pc only), then the odd word `mem_rdata[19:10]`, tagged with consecutive pcs. `fetch_pc` advances by need.
- Free-slot count uses the current-cycle occupancy. A same-cycle pop does not create room.
- Pop: `ins_valid && ins_ready` removes the head.
- Wrap-around: `fetch_pc` and tags are modulo 2^ADDR_W. The address after 1023 is 0, and fetching continues.
- `start` or `redirect`: FIFO cleared; `fetch_pc` loads the target. Any fetch or pop in the same cycle is discarded. `redirect` has priority over `start`.
- A store in the same cycle as a redirect is still written.

## Timing
- Reset values: `ins_valid`=0, `ins_word`=0, `ins_pc`=0, FIFO empty, `fetch_pc`=0, state IDLE. `mem_we`=0 and `st_ready`=0 while in reset.
- Fetch→`ins_valid`: 1 cycle (words are registered at the edge ending the fetch cycle).
- After `start` or `redirect`, the first fetch occurs the next cycle, and the first `ins_valid` follows 2 cycles after the pulse.
- A store takes the port for exactly the cycle `st_valid`=1. Fetch stalls that cycle. Stores are never stalled.
- Steady state with `ins_ready`=1 and DEPTH≥4: one pair per cycle whenever ≥2 slots are free.

## Configuration
- `IFETCH_SNOOP_EN` defined: an accepted store whose `st_addr` matches the tag of any valid FIFO entry, or whose pair matches the pair being fetched that cycle, flushes the FIFO. `fetch_pc` reloads to the oldest discarded tag (the head tag if the FIFO was non-empty). This makes self-modifying code coherent. Snoop flush and redirect in the same cycle: redirect wins.
- Not defined: no snooping. Stale words may issue, and software must branch after writing code.

## Structure
- Shared package `ifetch_pkg`: `ADDR_W`/`WORD_W` defaults, the state enum (IDLE, RUN), and a word+pc entry typedef.
- One sub-module: `ifetch_fifo`. It is a synchronous word+tag FIFO with 2-wide push (push count 0/1/2), 1-wide pop, clear, and a `free` count output.

## Test plan
- Preload ram[0]=0x00A, ram[1]=0x240, ram[2]=0x14B; `start` with `start_addr`=0, `ins_ready`=1 → words 0x00A, 0x240, 0x14B with `ins_pc` 0, 1, 2. First `ins_valid` 2 cycles after `start`.
- `start_addr`=1 → first word 0x240 at pc 1 (single odd push), then 0x14B at pc 2.
- `ins_ready`=0, DEPTH=4, start at 0 → exactly 4 words buffered and fetch halts. Raising `ins_ready` drains pcs 0..3 in order, then fetch resumes at 4.
- `st_valid` with `st_addr`=12, `st_data`=0x007 during streaming → `mem_we`=1 and `mem_addr`=12 that cycle. Fetch pc is unchanged, and no word is lost or duplicated.
- `redirect` to 50 while FIFO is non-empty, same cycle as a pop → `ins_valid`=0 next cycle, then pcs 50, 51, …. Start at 1022 → pcs 1022, 1023, 0, 1.
- With `IFETCH_SNOOP_EN`: buffer pcs 0..3, then store 0x3FF to address 2 → flush, refetch from pc 0, and pc 2 issues 0x3FF. Without the macro, the old word issues.
